logic_unit_acc: RTL

LOGIC_UNIT_ACC -- requirements
Module: logic_unit_acc

---
 rtl/logic_unit_pkg.sv | 20 ++
 rtl/logic_op.sv | 28 ++
 rtl/logic_unit_acc.sv | 100 ++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types for the logic unit: operation codes and accumulator FSM states.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_NAND  = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_X = 3'd6,
        OP_PASS_Y = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_op.sv
// Combinational bitwise function f(x,y) selected by a 3-bit op code.
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (op_e'(op))
            OP_AND:    f = x & y;
            OP_NAND:   f = ~(x & y);
            OP_OR:     f = x | y;
            OP_NOR:    f = ~(x | y);
            OP_XOR:    f = x ^ y;
            OP_XNOR:   f = ~(x ^ y);
            OP_NOT_X:  f = ~x;
            OP_PASS_Y: f = y;
            default:   f = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_acc.sv
// Bitwise logic unit with direct and accumulate modes behind a valid/ready result register.
// Optional LOGIC_UNIT_REDUCE_EN adds registered reduction flags of each loaded result.
module logic_unit_acc
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             acc_mode,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    output logic             out_and_r,
    output logic             out_or_r,
    output logic             out_xor_r
`endif
);

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH-1:0] f_out;
    logic [WIDTH-1:0] load_val;
    logic             xfer;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == ST_ACC);

    assign op_x = busy ? acc : a;
    assign op_y = busy ? a   : b;

    logic_op #(.WIDTH(WIDTH)) u_logic_op (
        .op (op),
        .x  (op_x),
        .y  (op_y),
        .f  (f_out)
    );

    // The first beat of an accumulate stream takes a unmodified; all other beats use f.
    assign load_val = (!busy && acc_mode) ? a : f_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef LOGIC_UNIT_REDUCE_EN
            out_and_r <= 1'b0;
            out_or_r  <= 1'b0;
            out_xor_r <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (xfer) begin
                if (busy || acc_mode) begin
                    if (in_last) begin
                        out_data  <= load_val;
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
`ifdef LOGIC_UNIT_REDUCE_EN
                        out_and_r <= &load_val;
                        out_or_r  <= |load_val;
                        out_xor_r <= ^load_val;
`endif
                    end else begin
                        acc   <= load_val;
                        state <= ST_ACC;
                    end
                end else begin
                    out_data  <= load_val;
                    out_last  <= in_last;
                    out_valid <= 1'b1;
`ifdef LOGIC_UNIT_REDUCE_EN
                    out_and_r <= &load_val;
                    out_or_r  <= |load_val;
                    out_xor_r <= ^load_val;
`endif
                end
            end
        end
    end

endmodule
